pixel_frame_collector: RTL

Collects a serial stream of grayscale pixels (row-major, one pixel per handshake) into the flat 784-pixel frame vector consumed by `average_pooling_wrapper`. The block sits directly upstream of the pooling stage. It buffers one full frame and raises `frame_valid` when the frame is complete. It then holds the frame stable until the consumer acknowledges it, and stalls the pixel source during that time.

---
 rtl/pooling_pkg.sv | 14 +
 rtl/pixel_index_counter.sv | 41 ++++
 rtl/pixel_frame_collector.sv | 116 +++++++++++
 3 files changed

// File: rtl/pooling_pkg.sv
// Shared types and sizing for the pooling front end (frame collector and pooling wrapper).
package pooling_pkg;

  localparam int IMG_SIDE      = 28;
  localparam int RESOLUTION    = 8;
  localparam int PIXELS_NUMBER = IMG_SIDE * IMG_SIDE;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } collector_state_t;

endpackage

// File: rtl/pixel_index_counter.sv
// Frame slot index: clear beats load-to-1, which beats increment; flags the last slot of a frame.
module pixel_index_counter
  import pooling_pkg::*;
#(
  parameter int pixels_number = PIXELS_NUMBER,
  localparam int IDX_W        = $clog2(pixels_number)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             load_one_i,
  input  logic             clear_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (load_one_i) begin
      idx_d = IDX_W'(1);
    end else if (inc_i) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_W'(pixels_number - 1));

endmodule

// File: rtl/pixel_frame_collector.sv
// Assembles a row-major pixel stream into one flat frame and holds it until acknowledged.
// Optional SOF resynchronisation is enabled by defining PIXEL_FRAME_COLLECTOR_SOF_RESYNC_EN.
module pixel_frame_collector
  import pooling_pkg::*;
#(
  parameter int resolution    = RESOLUTION,
  parameter int pixels_number = PIXELS_NUMBER
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [resolution-1:0]               pix_in,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  input  logic                                pix_sof,
  output logic [resolution*pixels_number-1:0] frame_out,
  output logic                                frame_valid,
  input  logic                                frame_ack,
  output logic                                frame_drop
);

  localparam int IDX_W = $clog2(pixels_number);

  collector_state_t state_q, state_d, stateNext;
  logic                                rstDone_q;
  logic [resolution*pixels_number-1:0] frame_q;
  logic                                pixReady_q, frameValid_q, frameDrop_q;
  logic                                drop_d;

  logic [IDX_W-1:0] idx, wrIdx;
  logic             idxLast, cntInc, cntLoad, cntClear;
  logic             beatAccepted, sofBeat;

  pixel_index_counter #(
    .pixels_number(pixels_number)
  ) u_index (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (cntInc),
    .load_one_i(cntLoad),
    .clear_i   (cntClear),
    .idx_o     (idx),
    .last_o    (idxLast)
  );

  assign beatAccepted = pix_valid && pixReady_q;

`ifdef PIXEL_FRAME_COLLECTOR_SOF_RESYNC_EN
  assign sofBeat = beatAccepted && pix_sof;
`else
  logic unusedSof;
  assign unusedSof = pix_sof;
  assign sofBeat   = 1'b0;
`endif

  assign wrIdx = sofBeat ? '0 : idx;

  // A SOF beat wins over frame completion, so a SOF on the last slot restarts the frame.
  always_comb begin
    state_d  = state_q;
    drop_d   = 1'b0;
    cntInc   = 1'b0;
    cntLoad  = 1'b0;
    cntClear = 1'b0;
    case (state_q)
      IDLE: state_d = COLLECT;
      COLLECT: begin
        if (sofBeat) begin
          cntLoad = 1'b1;
          drop_d  = (idx != '0);
        end else if (beatAccepted) begin
          if (idxLast) begin
            cntClear = 1'b1;
            state_d  = FULL;
          end else begin
            cntInc = 1'b1;
          end
        end
      end
      FULL: if (frame_ack) state_d = COLLECT;
      default: state_d = IDLE;
    endcase
  end

  // The first edge after reset release only re-enters IDLE, so pix_ready rises two edges after release.
  assign stateNext = rstDone_q ? state_d : IDLE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rstDone_q    <= 1'b0;
      state_q      <= IDLE;
      pixReady_q   <= 1'b0;
      frameValid_q <= 1'b0;
      frameDrop_q  <= 1'b0;
    end else begin
      rstDone_q    <= 1'b1;
      state_q      <= stateNext;
      pixReady_q   <= (stateNext == COLLECT);
      frameValid_q <= (stateNext == FULL);
      frameDrop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_q <= '0;
    end else if (beatAccepted) begin
      frame_q[int'(wrIdx)*resolution +: resolution] <= pix_in;
    end
  end

  assign pix_ready   = pixReady_q;
  assign frame_valid = frameValid_q;
  assign frame_drop  = frameDrop_q;
  assign frame_out   = frame_q;

endmodule
